// File: rtl/bram_port_arbiter.sv
// Two-requester front end for a single-port BRAM: round-robin grant, fixed
// three-cycle transaction (accept, access, response) with range checking.
module bram_port_arbiter #(
  parameter logic [31:0] MEM_BYTES = 32'h00008000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_addr,
  input  logic [3:0]  req0_wstrb,
  input  logic [31:0] req0_wdata,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_addr,
  input  logic [3:0]  req1_wstrb,
  input  logic [31:0] req1_wdata,
  output logic        rsp0_valid,
  output logic [31:0] rsp0_rdata,
  output logic        rsp0_err,
  output logic        rsp1_valid,
  output logic [31:0] rsp1_rdata,
  output logic        rsp1_err,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t      state_q, state_d;
  logic        ptr_q, ptr_d;
  logic        id_q, id_d;
  logic        in_range_q, in_range_d;
  logic [3:0]  mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [1:0]  rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;

  logic        gnt_id;
  logic        accept;
  logic [31:0] sel_addr;
  logic [3:0]  sel_wstrb;
  logic [31:0] sel_wdata;
  logic        sel_in_range;

  // On a tie the requester that was not served last wins.
  always_comb begin
    gnt_id = req1_valid;
    if (req0_valid && req1_valid) gnt_id = ~ptr_q;
    accept       = (state_q == IDLE) && (req0_valid || req1_valid);
    sel_addr     = gnt_id ? req1_addr  : req0_addr;
    sel_wstrb    = gnt_id ? req1_wstrb : req0_wstrb;
    sel_wdata    = gnt_id ? req1_wdata : req0_wdata;
    sel_in_range = sel_addr < MEM_BYTES;
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    in_range_d  = in_range_q;
    mem_we_d    = 4'b0000;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rsp_valid_d = 2'b00;
    rsp_err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d     = ISSUE;
          ptr_d       = gnt_id;
          id_d        = gnt_id;
          in_range_d  = sel_in_range;
          mem_addr_d  = {sel_addr[31:2], 2'b00};
          mem_wdata_d = sel_wdata;
          mem_we_d    = sel_in_range ? sel_wstrb : 4'b0000;
        end
      end
      ISSUE: begin
        state_d     = RESP;
        rsp_valid_d = id_q ? 2'b10 : 2'b01;
        rsp_err_d   = ~in_range_q;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b1;
      id_q        <= 1'b0;
      in_range_q  <= 1'b0;
      mem_we_q    <= 4'b0000;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      rsp_valid_q <= 2'b00;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      in_range_q  <= in_range_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req0_ready = accept && !gnt_id && !rst;
  assign req1_ready = accept &&  gnt_id && !rst;

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  // BRAM read data only exists during RESP, so response data is gated, not latched.
  assign rsp0_valid = rsp_valid_q[0];
  assign rsp1_valid = rsp_valid_q[1];
  assign rsp0_err   = rsp_valid_q[0] & rsp_err_q;
  assign rsp1_err   = rsp_valid_q[1] & rsp_err_q;
  assign rsp0_rdata = (rsp_valid_q[0] && !rsp_err_q) ? mem_rdata : 32'h0;
  assign rsp1_rdata = (rsp_valid_q[1] && !rsp_err_q) ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Randomized and directed bench for bram_port_arbiter against a transaction-level
// model (grant rule, fixed latency, shadow memory) plus a behavioural BRAM.
module tb_bram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 0, req1_valid = 0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_addr = 0, req1_addr = 0;
  logic [3:0]  req0_wstrb = 0, req1_wstrb = 0;
  logic [31:0] req0_wdata = 0, req1_wdata = 0;
  logic        rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
  logic [31:0] rsp0_rdata, rsp1_rdata;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 32'h0;

  bram_port_arbiter #(.MEM_BYTES(32'h00008000)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr),
    .req0_wstrb(req0_wstrb), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr),
    .req1_wstrb(req1_wstrb), .req1_wdata(req1_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural BRAM: registered read-first, address aliases on the low 15 bits.
  logic [31:0] bram [8192];
  always @(posedge clk) begin
    mem_rdata <= bram[mem_addr[14:2]];
    for (int b = 0; b < 4; b++)
      if (mem_we[b]) bram[mem_addr[14:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model state
  logic [31:0] ref_mem [8192];
  logic        last_srv = 1'b1;
  bit          pend_v = 0;
  int          pend_acc = 0;
  logic        pend_id = 0;
  logic [31:0] pend_addr = 0, pend_wdata = 0, pend_rdata = 0;
  logic [3:0]  pend_strb = 0;
  int          cyc = 0;
  int          g;

  function automatic bit inr(input logic [31:0] a);
    return a < 32'h00008000;
  endfunction

  // One clock cycle: drive at the falling edge, check 1 ns later, advance the model.
  task automatic step(input logic v0, input logic [31:0] a0, input logic [3:0] s0,
                      input logic [31:0] d0, input logic v1, input logic [31:0] a1,
                      input logic [3:0] s1, input logic [31:0] d1, output int gnt);
    bit issue, resp;
    logic [12:0] idx;
    req0_valid = v0; req0_addr = a0; req0_wstrb = s0; req0_wdata = d0;
    req1_valid = v1; req1_addr = a1; req1_wstrb = s1; req1_wdata = d1;
    #1;
    gnt = -1;
    if (!pend_v && (v0 || v1)) gnt = (v0 && v1) ? (last_srv ? 0 : 1) : (v1 ? 1 : 0);
    chk("ready0", 32'(req0_ready), 32'(gnt == 0));
    chk("ready1", 32'(req1_ready), 32'(gnt == 1));
    issue = pend_v && (cyc == pend_acc + 1);
    resp  = pend_v && (cyc == pend_acc + 2);
    chk("mem_we", 32'(mem_we), (issue && inr(pend_addr)) ? 32'(pend_strb) : 32'h0);
    if (issue) begin
      chk("mem_addr", mem_addr, {pend_addr[31:2], 2'b00});
      chk("mem_wdata", mem_wdata, pend_wdata);
      idx = pend_addr[14:2];
      pend_rdata = inr(pend_addr) ? ref_mem[idx] : 32'h0;
      if (inr(pend_addr))
        for (int b = 0; b < 4; b++)
          if (pend_strb[b]) ref_mem[idx][b*8 +: 8] = pend_wdata[b*8 +: 8];
    end
    chk("rsp0_valid", 32'(rsp0_valid), 32'(resp && pend_id == 1'b0));
    chk("rsp1_valid", 32'(rsp1_valid), 32'(resp && pend_id == 1'b1));
    if (resp) begin
      if (pend_id) begin
        chk("rsp1_rdata", rsp1_rdata, pend_rdata);
        chk("rsp1_err", 32'(rsp1_err), 32'(!inr(pend_addr)));
      end else begin
        chk("rsp0_rdata", rsp0_rdata, pend_rdata);
        chk("rsp0_err", 32'(rsp0_err), 32'(!inr(pend_addr)));
      end
      pend_v = 0;
    end
    if (gnt >= 0) begin
      pend_v     = 1;
      pend_acc   = cyc;
      pend_id    = gnt[0];
      pend_addr  = gnt[0] ? a1 : a0;
      pend_strb  = gnt[0] ? s1 : s0;
      pend_wdata = gnt[0] ? d1 : d0;
      last_srv   = gnt[0];
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle_step();
    int dummy;
    step(1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0, dummy);
  endtask

  task automatic drain();
    for (int i = 0; i < 5 && pend_v; i++) idle_step();
    if (pend_v) chk("drain_timeout", 32'(pend_v), 32'h0);
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 32'h00008000 + 32'($urandom_range(0, 255));
    if (r == 1) return 32'hFFFFFFFC | 32'($urandom_range(0, 3));
    return (r < 6 ? 32'h0 : 32'h00007F80) | 32'($urandom_range(0, 127));
  endfunction

  function automatic logic [3:0] rand_strb();
    if ($urandom_range(0, 1) == 0) return 4'h0;
    return 4'($urandom_range(1, 15));
  endfunction

  int gseq[$];
  int bad_words;

  initial begin
    for (int i = 0; i < 8192; i++) begin
      bram[i]    = $urandom;
      ref_mem[i] = bram[i];
    end
    req0_valid = 1; req1_valid = 1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready0", 32'(req0_ready), 32'h0);
    chk("rst_ready1", 32'(req1_ready), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_rsp", {rsp0_valid, rsp1_valid, rsp0_err, rsp1_err}, 32'h0);
    chk("rst_rdata", rsp0_rdata | rsp1_rdata, 32'h0);
    @(negedge clk);
    rst = 0;

    // Contention: both requesters continuously valid for 12 cycles.
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 32'h40 + 32'(i * 4), 4'h0, 32'h0, 1'b1, 32'h80 + 32'(i * 4), 4'h0, 32'h0, g);
      if (g >= 0) gseq.push_back(g);
    end
    chk("contention_count", 32'(gseq.size()), 32'd4);
    for (int i = 0; i < 4 && i < gseq.size(); i++)
      chk("contention_order", 32'(gseq[i]), 32'(i % 2));
    drain();

    // Directed read, byte write then read-back, out-of-range write.
    step(1'b1, 32'h10, 4'h0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0, g);
    drain();
    step(1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h5003, 4'b0100, 32'h00AB0000, g);
    drain();
    step(1'b1, 32'h5000, 4'h0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0, g);
    drain();
    chk("byte_write", 32'(bram[32'h5000 >> 2][23:16]), 32'hAB);
    step(1'b1, 32'h8000, 4'hF, 32'hDEADBEEF, 1'b0, 32'h0, 4'h0, 32'h0, g);
    drain();

    // Reset during ISSUE of a write aborts it.
    step(1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h100, 4'hF, 32'h12345678, g);
    req1_valid = 0;
    #1;
    chk("abort_issue_we", 32'(mem_we), 32'hF);
    rst = 1;
    #1;
    chk("abort_we_async", 32'(mem_we), 32'h0);
    pend_v = 0; last_srv = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("abort_no_rsp", {30'h0, rsp0_valid, rsp1_valid}, 32'h0);
    end
    chk("abort_no_write", bram[32'h100 >> 2], ref_mem[32'h100 >> 2]);
    @(negedge clk);
    rst = 0;
    step(1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h104, 4'h0, 32'h0, g);
    chk("post_rst_grant", 32'(g), 32'd1);
    drain();

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 3) != 0, rand_addr(), rand_strb(), $urandom,
           $urandom_range(0, 3) != 0, rand_addr(), rand_strb(), $urandom, g);
    end
    drain();
    idle_step();

    bad_words = 0;
    for (int i = 0; i < 8192; i++) if (bram[i] !== ref_mem[i]) bad_words++;
    chk("bram_contents", 32'(bad_words), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/bram_port_arbiter.md
BRAM_PORT_ARBITER -- requirements
Module: bram_port_arbiter

Interface
REQ-001 Parameter MEM_BYTES, default 32'h00008000, SHALL set the byte size of the backing BRAM; legal addresses are 0 to MEM_BYTES-1.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 reqN_valid  input  1  requester N (N=0,1) presents a request.
REQ-005 reqN_ready  output  1  request N accepted on this edge when reqN_valid is also high.
REQ-006 reqN_addr  input  32  byte address; bits [1:0] are ignored (word access).
REQ-007 reqN_wstrb  input  4  per-byte write enables; 4'b0000 means read.
REQ-008 reqN_wdata  input  32  write data, byte lanes per wstrb.
REQ-009 rspN_valid  output  1  one-cycle response pulse to requester N.
REQ-010 rspN_rdata  output  32  read data; valid only while rspN_valid is high.
REQ-011 rspN_err  output  1  out-of-range flag; valid only while rspN_valid is high.
REQ-012 mem_we  output  4  byte write enables to the BRAM port.
REQ-013 mem_addr  output  32  byte address to the BRAM port.
REQ-014 mem_wdata  output  32  write data to the BRAM port.
REQ-015 mem_rdata  input  32  registered BRAM read data, one cycle after the address; read-first.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, ISSUE and RESP, with transitions IDLE->ISSUE on accept, ISSUE->RESP always, and RESP->IDLE always.
REQ-017 In IDLE, reqN_ready SHALL be high only for the granted requester; both readys SHALL be 0 in ISSUE and RESP.
REQ-018 Grant SHALL be combinational from the valids and a 1-bit last-served pointer.
- Only one valid: that requester is granted.
- Both valid: the requester not equal to the pointer is granted.
REQ-019 On accept, the block SHALL latch the requester id, addr, wstrb and wdata, set the pointer to the accepted id, and enter ISSUE.
REQ-020 In ISSUE, mem_addr SHALL equal {latched addr[31:2],2'b00} and mem_wdata SHALL equal the latched wdata.
REQ-021 In ISSUE, mem_we SHALL equal the latched wstrb when the address is in range, and 4'b0000 otherwise.
REQ-022 In-range SHALL be defined as latched addr < MEM_BYTES, compared unsigned at 32 bits.
REQ-023 In RESP, rspN_valid SHALL be 1 only for the latched id.
- rspN_rdata = mem_rdata when in range, 32'h0 when out of range.
- rspN_err = 1 exactly when out of range.
REQ-024 A write SHALL also produce a response; its rdata is the word's pre-write contents (read-first).
REQ-025 mem_we SHALL be 4'b0000 in every state except ISSUE; mem_addr and mem_wdata SHALL hold their last values outside ISSUE.
REQ-026 Latency SHALL be fixed: accept edge at cycle T, BRAM access edge at T+1, rspN_valid high during cycle T+2.
REQ-027 Peak throughput SHALL be one request per 3 cycles.
REQ-028 Requests need not be held stable after accept; changing reqN_* after the accept edge SHALL NOT affect the in-flight transaction.
REQ-029 Dropping reqN_valid before accept SHALL be legal and SHALL NOT change the pointer.
REQ-030 No response back-pressure exists; the requester SHALL sample rspN_* in the cycle rspN_valid is high.
REQ-031 With both requesters continuously valid, grants SHALL strictly alternate 0,1,0,1...; no requester waits more than one foreign transaction.

Reset
REQ-032 While rst is high, asynchronously:
- state = IDLE, pointer = 1 (requester 0 wins the first tie)
- mem_we = 0, mem_addr = 0, mem_wdata = 0
- rsp0/1_valid = 0, rsp0/1_err = 0, rsp0/1_rdata = 0
- req0/1_ready = 0
REQ-033 Reset asserted in ISSUE or RESP SHALL abort the transaction: no response pulse, and mem_we deasserts immediately without waiting for a clock edge.
REQ-034 After rst deasserts, the first accept SHALL be possible on the first rising edge.

Verification
REQ-035 Read: req0 addr 0x10, wstrb 0 -> ready0 at T, mem_addr 0x10 at T+1, rsp0_valid at T+2 with rdata = mem[4], err 0.
REQ-036 Byte write: req1 addr 0x5003, wstrb 4'b0100, wdata 0x00AB0000 -> mem_we 4'b0100 and mem_addr 0x5000 in ISSUE; a following read returns byte 2 = 0xAB, other bytes unchanged.
REQ-037 Contention: both valid continuously for 12 cycles after reset -> grant order 0,1,0,1; one rsp pulse every 3 cycles; never both ready or both rsp_valid.
REQ-038 Out of range: req0 addr 0x8000, wstrb 4'hF -> mem_we stays 0, rsp0_valid with err 1, rdata 0; BRAM contents unchanged.
REQ-039 Reset mid-op: rst asserted during ISSUE of a write -> mem_we 0 before the next edge; no rsp pulse; after release, req1-only valid is granted at the first edge.
